filter_event_ctrl: RTL
======================

// Module: filter_event_ctrl
// PURPOSE
//  Run/event controller for the trapezoidal shaping filter on one ADC channel. Releases the filter
//  from reset, waits out pipeline settling, then arms a signed threshold trigger on the filter output.
//  For each trigger it finds the peak over a fixed window and applies dead time. It presents
//  {amplitude, timestamp} to readout through a one-entry valid/ready output register.
// PARAMETERS
//  SIZE_FILTER_DATA  16   width of filter output and threshold, two's complement
//  SETTLE_CYCLES     16   cycles after filter reset release before triggering is allowed (>=1)
//  PEAK_WIN          8    samples searched for the maximum, starting at the crossing sample (>=1)
//  DEAD_TIME         32   cycles after window end during which no trigger is accepted (>=1)
//  TS_W              32   timestamp counter width
// PORTS
//  clk           in   1                  system clock, all logic on rising edge
//  reset         in   1                  synchronous, active-low; clears all state
//  enable        in   1                  run request; level-sensitive
//  threshold     in   SIZE_FILTER_DATA   signed trigger level; sampled every cycle
//  filter_data   in   SIZE_FILTER_DATA   signed filter output, one sample per clk
//  filter_rst_n  out  1                  active-low reset driven to the filter
//  busy          out  1                  high in any state other than IDLE
//  evt_valid     out  1                  event register holds an unread event
//  evt_ready     in   1                  readout accepts the event when high together with evt_valid
//  evt_amp       out  SIZE_FILTER_DATA   signed peak value within the window
//  evt_time      out  TS_W               timestamp of the crossing sample
//  drop_cnt      out  8                  events discarded, saturating at 255
// BEHAVIOUR
//  Reset (reset=0 at an edge): state=IDLE; filter_rst_n=0, busy=0, evt_valid=0, evt_amp=0,
//   evt_time=0, drop_cnt=0; timestamp=0. Reset overrides everything, including a pending event.
//  All outputs are registered.
//  FSM:
//   IDLE: filter_rst_n=0. If enable=1 at edge e: go to SETTLE, filter_rst_n=1, timestamp=0,
//    settle counter=0.
//   SETTLE: the counter increments each edge. Enter ARMED at edge e+SETTLE_CYCLES.
//   ARMED: if filter_data > threshold (strict, signed) at edge k0: enter PEAK, peak=filter_data,
//    evt time latch=timestamp, window count=1.
//   PEAK: on each edge, peak=max(peak, filter_data). After PEAK_WIN samples (edges k0..k0+PEAK_WIN-1),
//    at edge k0+PEAK_WIN: finalize the event and enter DEAD.
//   DEAD: count DEAD_TIME edges, then ARMED. The first new compare happens at edge
//    k0+PEAK_WIN+DEAD_TIME+1.
//  enable=0 seen at any edge in SETTLE/ARMED/PEAK/DEAD: go to IDLE with filter_rst_n=0 at that edge.
//   An event in progress is abandoned without counting. An event already in the output register
//   is kept until accepted.
//  Timestamp: free-running from SETTLE entry, +1 per edge, wraps modulo 2^TS_W with no flag.
//   Held at its value in IDLE.
//  Finalize: if evt_valid=0, or evt_valid=1 and evt_ready=1 on the same edge, load evt_amp/evt_time
//   and set evt_valid=1. Otherwise (register still full) discard the event and increment drop_cnt.
//  Handshake: evt_valid stays high and evt_* stay stable until an edge with evt_ready=1.
//   evt_valid falls at that edge unless it is reloaded by a finalize on the same edge.
//   evt_ready is ignored while evt_valid=0.
//  drop_cnt saturates at 255 and holds. It is cleared only by reset.
//  Threshold changes take effect on the next compare. PEAK ignores the threshold.
// CONFIGURATION
//  FILTER_PILEUP_REJECT_EN defined:
//   - In PEAK, a re-crossing sets a pileup flag. A re-crossing is a sample <= threshold followed
//     later in the window by a sample > threshold.
//   - At finalize, a flagged event is discarded; drop_cnt increments and evt_valid is unaffected.
//  FILTER_PILEUP_REJECT_EN undefined: re-crossings are ignored and every completed window is finalized.
// TESTING
//  1 reset=0 mid-PEAK with evt_valid=1 -> next cycle all outputs at reset values, filter_rst_n=0.
//  2 enable rises at edge 10, SETTLE_CYCLES=16, filter_data=1000, threshold=100 -> no trigger
//    before ARMED; crossing at edge 27 -> evt_time=17.
//  3 Window samples 200,350,500,420,300,...(PEAK_WIN=8), threshold=150 -> evt_amp=500; evt_valid
//    rises at edge k0+8.
//  4 evt_ready=0 and two events complete -> first held stable, second dropped, drop_cnt=1;
//    finalize on the same edge as evt_ready=1 -> new event loaded, evt_valid stays 1.
//  5 Crossing during DEAD (1 cycle after window end) -> ignored, no event; crossing at the first
//    ARMED compare -> triggers.
//  6 PILEUP on, window 200,90,300, threshold=100 -> no event, drop_cnt+1.
//    PILEUP off -> evt_amp=300.

Source files
------------

// File: rtl/filter_event_ctrl_if.sv
// Event readout channel: one {amplitude, timestamp} record per valid/ready handshake.
interface filter_event_ctrl_if #(
   parameter int unsigned DataW = 16,
   parameter int unsigned TsW   = 32
);
   logic                    evt_valid;
   logic                    evt_ready;
   logic signed [DataW-1:0] evt_amp;
   logic [TsW-1:0]          evt_time;

   modport master (
      output evt_valid,
      output evt_amp,
      output evt_time,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_amp,
      input  evt_time,
      output evt_ready
   );
endinterface

// File: rtl/filter_event_ctrl.sv
// Run/event controller for a trapezoidal filter: settle, threshold trigger, peak window, dead time.
// Optional pileup rejection is compiled in with FILTER_PILEUP_REJECT_EN.
module filter_event_ctrl #(
   parameter int unsigned SIZE_FILTER_DATA = 16,
   parameter int unsigned SETTLE_CYCLES    = 16,
   parameter int unsigned PEAK_WIN         = 8,
   parameter int unsigned DEAD_TIME        = 32,
   parameter int unsigned TS_W             = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enable,
   input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
   input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
   output logic                               filter_rst_n,
   output logic                               busy,
   filter_event_ctrl_if.master                evt,
   output logic [7:0]                         drop_cnt
);

   typedef enum logic [2:0] {StIdle, StSettle, StArmed, StPeak, StDead} state_e;

   localparam logic [TS_W-1:0] TsOne = 1;

   state_e                             state_q, state_d;
   logic [31:0]                        cnt_q, cnt_d;
   logic [TS_W-1:0]                    ts_q, ts_d;
   logic [TS_W-1:0]                    tlatch_q, tlatch_d;
   logic signed [SIZE_FILTER_DATA-1:0] peak_q, peak_d;
   logic                               finalize;
   logic                               reject;
   logic                               accept;

   logic                               valid_q, valid_d;
   logic signed [SIZE_FILTER_DATA-1:0] amp_q, amp_d;
   logic [TS_W-1:0]                    time_q, time_d;
   logic [7:0]                         drop_q, drop_d;
   logic                               run_q;

`ifdef FILTER_PILEUP_REJECT_EN
   logic below_q, below_d;
   logic pile_q, pile_d;
   assign reject = pile_q;
`else
   assign reject = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ts_d     = ts_q;
      tlatch_d = tlatch_q;
      peak_d   = peak_q;
      finalize = 1'b0;
`ifdef FILTER_PILEUP_REJECT_EN
      below_d  = below_q;
      pile_d   = pile_q;
`endif
      if (state_q != StIdle) ts_d = ts_q + TsOne;

      unique case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StSettle;
               cnt_d   = '0;
               ts_d    = '0;
            end
         end
         StSettle: begin
            if (cnt_q == SETTLE_CYCLES - 1) state_d = StArmed;
            else cnt_d = cnt_q + 32'd1;
         end
         StArmed: begin
            if (filter_data > threshold) begin
               state_d  = StPeak;
               peak_d   = filter_data;
               // Timestamp of the crossing edge is the value the counter takes at that edge.
               tlatch_d = ts_q + TsOne;
               cnt_d    = 32'd1;
`ifdef FILTER_PILEUP_REJECT_EN
               below_d  = 1'b0;
               pile_d   = 1'b0;
`endif
            end
         end
         StPeak: begin
            if (cnt_q == PEAK_WIN) begin
               finalize = 1'b1;
               state_d  = StDead;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
               if (filter_data > peak_q) peak_d = filter_data;
`ifdef FILTER_PILEUP_REJECT_EN
               if (filter_data <= threshold) below_d = 1'b1;
               else if (below_q) pile_d = 1'b1;
`endif
            end
         end
         StDead: begin
            if (cnt_q == DEAD_TIME - 1) state_d = StArmed;
            else cnt_d = cnt_q + 32'd1;
         end
         default: state_d = StIdle;
      endcase

      // Dropping enable abandons any event still in the window.
      if (state_q != StIdle && !enable) begin
         state_d  = StIdle;
         finalize = 1'b0;
      end
   end

   always_comb begin
      accept  = finalize && !reject && (!valid_q || evt.evt_ready);
      valid_d = valid_q;
      amp_d   = amp_q;
      time_d  = time_q;
      drop_d  = drop_q;
      if (valid_q && evt.evt_ready) valid_d = 1'b0;
      if (accept) begin
         valid_d = 1'b1;
         amp_d   = peak_q;
         time_d  = tlatch_q;
      end
      if (finalize && !accept && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         ts_q     <= '0;
         tlatch_q <= '0;
         peak_q   <= '0;
         valid_q  <= 1'b0;
         amp_q    <= '0;
         time_q   <= '0;
         drop_q   <= '0;
         run_q    <= 1'b0;
`ifdef FILTER_PILEUP_REJECT_EN
         below_q  <= 1'b0;
         pile_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ts_q     <= ts_d;
         tlatch_q <= tlatch_d;
         peak_q   <= peak_d;
         valid_q  <= valid_d;
         amp_q    <= amp_d;
         time_q   <= time_d;
         drop_q   <= drop_d;
         run_q    <= (state_d != StIdle);
`ifdef FILTER_PILEUP_REJECT_EN
         below_q  <= below_d;
         pile_q   <= pile_d;
`endif
      end
   end

   assign filter_rst_n  = run_q;
   assign busy          = run_q;
   assign evt.evt_valid = valid_q;
   assign evt.evt_amp   = amp_q;
   assign evt.evt_time  = time_q;
   assign drop_cnt      = drop_q;

endmodule
